amp_ramp_ctrl: RTL
==================

AMP_RAMP_CTRL -- requirements
Module: amp_ramp_ctrl

Interface
REQ-001 Parameter STEP_MV, default 10: maximum voltage_mv change per applied step, in mV.
REQ-002 Parameter TICK_DIV, default 5000: minimum number of clk cycles between two applied steps.
REQ-003 Parameter MAX_MV, default 3000: upper clamp for any accepted target, in mV.
REQ-004 Parameter INIT_MV, default 0: voltage_mv and target value after reset.
REQ-005 Port clk, input, 1: single system clock; all logic rises on posedge clk.
REQ-006 Port rst, input, 1: synchronous reset, active-high.
REQ-007 Port mcu_valid, input, 1: MCU (STM32 register path) target request valid.
REQ-008 Port mcu_mv, input, 12: MCU requested target, in mV.
REQ-009 Port mcu_ready, output, 1: MCU request accepted when mcu_valid and mcu_ready are both high.
REQ-010 Port pid_valid, input, 1: closed-loop PID target request valid.
REQ-011 Port pid_mv, input, 12: PID requested target, in mV.
REQ-012 Port pid_ready, output, 1: PID request accepted when pid_valid and pid_ready are both high.
REQ-013 Port phase_wrap, input, 1: one-cycle pulse from the DDS phase accumulator at the waveform centre crossing.
REQ-014 Port voltage_mv, output, 12: registered amplitude, fed to the voltage scaler's voltage_mv input.
REQ-015 Port busy, output, 1: high whenever voltage_mv differs from the current target.
REQ-016 Port done, output, 1: one-cycle pulse when voltage_mv reaches the target.

Function
REQ-017 mcu_ready SHALL be 1 whenever rst is low; pid_ready SHALL be the inverse of mcu_valid, so MCU has fixed priority and a simultaneous PID request is stalled, not dropped.
REQ-018 The accepted value SHALL be clamped to MAX_MV and registered as the target on the acceptance cycle; a new acceptance mid-ramp SHALL overwrite the target without resetting the state or the tick counter.
REQ-019 The FSM SHALL have states IDLE, WAIT_TICK, WAIT_WRAP.
REQ-020 IDLE -> WAIT_TICK SHALL occur the cycle after a target differing from voltage_mv is registered, with the tick counter cleared to 0.
REQ-021 In WAIT_TICK the counter SHALL increment each cycle; when it reaches TICK_DIV-1, the FSM SHALL move to WAIT_WRAP.
REQ-022 In WAIT_WRAP with phase_wrap high, voltage_mv SHALL update on the next edge by min(STEP_MV, |target-voltage_mv|) toward the target; the FSM SHALL go to IDLE if equal afterward, else to WAIT_TICK with the counter cleared.
REQ-023 phase_wrap pulses in IDLE or WAIT_TICK SHALL be ignored; voltage_mv SHALL never change except per REQ-022.
REQ-024 If a retarget makes the target equal voltage_mv in WAIT_TICK or WAIT_WRAP, the FSM SHALL return to IDLE on the next cycle and pulse done.
REQ-025 done SHALL pulse for exactly one cycle on every transition into IDLE that is not caused by reset.
REQ-026 Step arithmetic SHALL use a 13-bit signed difference; voltage_mv SHALL never overshoot the target or exceed MAX_MV.

Reset
REQ-027 While rst is high, voltage_mv and the target SHALL be INIT_MV, the FSM SHALL be IDLE, the counter SHALL be 0, busy and done SHALL be 0, both readies SHALL be 0, and no request SHALL be accepted.
REQ-028 Reset asserted mid-ramp SHALL abandon the ramp with no done pulse; the first request after reset release SHALL be honoured on the next cycle.

Structure
REQ-029 Package amp_ctrl_pkg SHALL hold the FSM state encoding and the default values of STEP_MV, TICK_DIV, MAX_MV and INIT_MV.
REQ-030 Request arbitration and clamping (REQ-017, REQ-018) SHALL be a sub-module named amp_req_arbiter; the FSM, counter and step datapath SHALL stay in amp_ramp_ctrl.

Verification
REQ-031 Setup: TICK_DIV=4, STEP_MV=10, INIT 0. Stimulus: MCU request 25 with phase_wrap every cycle. Required: voltage_mv goes 10, 20, 25, with each step at least 4 cycles apart, one done pulse after 25, and busy low afterward.
REQ-032 Stimulus: MCU 100 and PID 200 valid in the same cycle. Required: target 100, pid_ready low that cycle; PID is accepted the next cycle and the target becomes 200.
REQ-033 Stimulus: request 4000. Required: target clamps to 3000, and voltage_mv never exceeds 3000.
REQ-034 Stimulus: ramp from 0 to 50 with phase_wrap withheld for 100 cycles. Required: voltage_mv stays 0 while the FSM is in WAIT_WRAP, then steps once on the first wrap.
REQ-035 Stimulus: ramp at 30 toward 100, then retarget to 30. Required: FSM returns to IDLE the next cycle, done pulses once, and voltage_mv stays 30.
REQ-036 Stimulus: rst asserted mid-ramp at 40. Required: voltage_mv becomes 0 on the next edge, with no done pulse and busy=0.

Source files
------------

// File: rtl/amp_ctrl_pkg.sv
// Shared FSM encoding, parameter defaults and the target clamp helper
// for the amplitude ramp controller.
package amp_ctrl_pkg;

   localparam int DEF_STEP_MV  = 10;
   localparam int DEF_TICK_DIV = 5000;
   localparam int DEF_MAX_MV   = 3000;
   localparam int DEF_INIT_MV  = 0;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TICK = 2'd1,
      ST_WAIT_WRAP = 2'd2
   } ramp_state_e;

   function automatic logic [11:0] clamp_mv(input logic [11:0] mv, input int max_mv);
      return (int'(mv) > max_mv) ? 12'(max_mv) : mv;
   endfunction

endpackage

// File: rtl/amp_req_arbiter.sv
// Fixed-priority MCU/PID target arbiter; presents the clamped accepted value.
// Purely combinational: the target register lives in amp_ramp_ctrl.
module amp_req_arbiter
   import amp_ctrl_pkg::*;
#(
   parameter int MAX_MV = DEF_MAX_MV
) (
   input  logic        rst,
   input  logic        mcu_valid,
   input  logic [11:0] mcu_mv,
   input  logic        pid_valid,
   input  logic [11:0] pid_mv,
   output logic        mcu_ready,
   output logic        pid_ready,
   output logic        acc_valid,
   output logic [11:0] acc_mv
);

   // PID is back-pressured rather than dropped while the MCU holds the port.
   always_comb begin
      mcu_ready = ~rst;
      pid_ready = ~rst & ~mcu_valid;
      acc_valid = (mcu_valid & mcu_ready) | (pid_valid & pid_ready);
      acc_mv    = clamp_mv(mcu_valid ? mcu_mv : pid_mv, MAX_MV);
   end

endmodule

// File: rtl/amp_ramp_ctrl.sv
// Slew-limited amplitude controller: steps voltage_mv toward the target at most
// STEP_MV per tick period, and only on a DDS centre crossing (phase_wrap).
module amp_ramp_ctrl
   import amp_ctrl_pkg::*;
#(
   parameter int STEP_MV  = DEF_STEP_MV,
   parameter int TICK_DIV = DEF_TICK_DIV,
   parameter int MAX_MV   = DEF_MAX_MV,
   parameter int INIT_MV  = DEF_INIT_MV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mcu_valid,
   input  logic [11:0] mcu_mv,
   output logic        mcu_ready,
   input  logic        pid_valid,
   input  logic [11:0] pid_mv,
   output logic        pid_ready,
   input  logic        phase_wrap,
   output logic [11:0] voltage_mv,
   output logic        busy,
   output logic        done
);

   localparam int                CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic signed [12:0] STEP_S  = 13'(STEP_MV);
   localparam logic [11:0]       STEP_U   = 12'(STEP_MV);
   localparam logic [11:0]       INIT_U   = 12'(INIT_MV);

   ramp_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [11:0]      target_q, target_d;
   logic [11:0]      volt_q, volt_d;
   logic             done_q, done_d;

   logic             acc_valid;
   logic [11:0]      acc_mv;
   logic signed [12:0] diff;
   logic [11:0]      stepped_mv;
   logic             at_target;

   amp_req_arbiter #(.MAX_MV(MAX_MV)) u_arb (
      .rst       (rst),
      .mcu_valid (mcu_valid),
      .mcu_mv    (mcu_mv),
      .pid_valid (pid_valid),
      .pid_mv    (pid_mv),
      .mcu_ready (mcu_ready),
      .pid_ready (pid_ready),
      .acc_valid (acc_valid),
      .acc_mv    (acc_mv)
   );

   // Final step lands exactly on the target, so no overshoot is possible.
   always_comb begin
      diff      = $signed({1'b0, target_q}) - $signed({1'b0, volt_q});
      at_target = (target_q == volt_q);
      if (diff > STEP_S)
         stepped_mv = volt_q + STEP_U;
      else if (diff < -STEP_S)
         stepped_mv = volt_q - STEP_U;
      else
         stepped_mv = target_q;
   end

   // NOTE: combinational next-state logic uses blocking '=' with every output
   // defaulted first, so no latches; the flops below use non-blocking '<='.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      volt_d   = volt_q;
      done_d   = 1'b0;
      target_d = acc_valid ? acc_mv : target_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!at_target) begin
               state_d = ST_WAIT_TICK;
               cnt_d   = '0;
            end
         end
         ST_WAIT_TICK: begin
            if (at_target) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_WAIT_WRAP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_WRAP: begin
            if (at_target) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else if (phase_wrap) begin
               volt_d = stepped_mv;
               if (stepped_mv == target_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_WAIT_TICK;
                  cnt_d   = '0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         target_q <= INIT_U;
         volt_q   <= INIT_U;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         target_q <= target_d;
         volt_q   <= volt_d;
         done_q   <= done_d;
      end
   end

   assign voltage_mv = volt_q;
   assign busy       = ~rst & ~at_target;
   assign done       = ~rst & done_q;

endmodule
